// File: rtl/vga_fill_pkg.sv
// Shared framebuffer geometry, fill FSM states and address packing.
package vga_fill_pkg;

  localparam int unsigned FB_W = 80;
  localparam int unsigned FB_H = 60;
  localparam int unsigned XW   = 7;
  localparam int unsigned YW   = 6;
  localparam int unsigned AW   = 13;
  localparam int unsigned CW   = 8;
  localparam int unsigned EW   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // Framebuffer address is row-major with a power-of-two row pitch.
  function automatic logic [AW-1:0] fb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_fill_engine_if.sv
// Single-cycle framebuffer write port (enable, address, data).
interface vga_fill_engine_if;
  import vga_fill_pkg::*;

  logic          we;
  logic [AW-1:0] wa;
  logic [CW-1:0] wd;

  modport master (output we, wa, wd);
  modport slave  (input  we, wa, wd);
endinterface

// File: rtl/fb_write_arbiter.sv
// Fixed-priority CPU-over-engine mux feeding the registered framebuffer port.
module fb_write_arbiter
  import vga_fill_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  vga_fill_engine_if.slave  cpu,
  vga_fill_engine_if.master fb,
  input  logic              eng_req_c,
  input  logic [AW-1:0]     eng_wa,
  input  logic [CW-1:0]     eng_wd,
  output logic              eng_grant_c
);

  // The engine only advances on cycles the CPU leaves the port free.
  assign eng_grant_c = eng_req_c & ~cpu.we;

  // Output register: CPU write, engine write, or an idle cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fb.we <= 1'b0;
      fb.wa <= '0;
      fb.wd <= '0;
    end else if (cpu.we) begin
      fb.we <= 1'b1;
      fb.wa <= cpu.wa;
      fb.wd <= cpu.wd;
    end else if (eng_req_c) begin
      fb.we <= 1'b1;
      fb.wa <= eng_wa;
      fb.wd <= eng_wd;
    end else begin
      fb.we <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_fill_engine.sv
// Rectangle-fill sequencer: clips a latched rectangle and walks it row-major.
module vga_fill_engine
  import vga_fill_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  vga_fill_engine_if.slave  cpu,
  vga_fill_engine_if.master fb,
  input  logic              START,
  input  logic              ABORT,
  input  logic [XW-1:0]     X0,
  input  logic [YW-1:0]     Y0,
  input  logic [XW-1:0]     W,
  input  logic [YW-1:0]     H,
  input  logic [CW-1:0]     COLOR,
  output logic              BUSY,
  output logic              DONE
);

  fill_state_t   state, next_state;
  logic [XW-1:0] x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [YW-1:0] y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic [CW-1:0] color_q, color_d;
  logic [EW-1:0] x_end_q, x_end_d, y_end_q, y_end_d;
  logic          last_q, last_d;
  logic [EW-1:0] x_sum_c, y_sum_c;
  logic          empty_c, eng_req_c, eng_grant_c;

  // Clip bounds and empty-rectangle detection from the latched request.
  always_comb begin
    x_sum_c = EW'(x0_q) + EW'(w_q);
    y_sum_c = EW'(y0_q) + EW'(h_q);
    empty_c = (w_q == '0) || (h_q == '0) ||
              (EW'(x0_q) >= EW'(FB_W)) || (EW'(y0_q) >= EW'(FB_H));
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; last_q marks the cycle after the final pixel was granted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (START) next_state = CLIP;
      CLIP: if (ABORT || empty_c) next_state = vga_fill_pkg::DONE;
            else next_state = FILL;
      FILL: if (ABORT || last_q) next_state = vga_fill_pkg::DONE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath next values and the engine write request.
  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    last_d    = last_q;
    eng_req_c = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          x0_d    = X0;
          y0_d    = Y0;
          w_d     = W;
          h_d     = H;
          color_d = COLOR;
        end
      end
      CLIP: begin
        x_end_d = (x_sum_c > EW'(FB_W)) ? EW'(FB_W) : x_sum_c;
        y_end_d = (y_sum_c > EW'(FB_H)) ? EW'(FB_H) : y_sum_c;
        cx_d    = x0_q;
        cy_d    = y0_q;
        last_d  = 1'b0;
      end
      FILL: begin
        eng_req_c = ~ABORT & ~last_q;
        if (eng_grant_c) begin
          if (EW'(cx_q) + EW'(1) == x_end_q) begin
            cx_d = x0_q;
            if (EW'(cy_q) + EW'(1) == y_end_q) last_d = 1'b1;
            else cy_d = cy_q + YW'(1);
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
      default: last_d = 1'b0;
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      last_q  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      last_q  <= last_d;
      BUSY    <= (next_state != IDLE);
      DONE    <= (next_state == vga_fill_pkg::DONE);
    end
  end

  fb_write_arbiter u_arb (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .cpu         (cpu),
    .fb          (fb),
    .eng_req_c   (eng_req_c),
    .eng_wa      (fb_addr(cx_q, cy_q)),
    .eng_wd      (color_q),
    .eng_grant_c (eng_grant_c)
  );

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed bench for vga_fill_engine: vector table plus hand-written corner sequences.
module tb_vga_fill_engine;
  import vga_fill_pkg::*;

  localparam int NCYC = 24;
  localparam int NVEC = 6;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [XW-1:0] X0    = '0;
  logic [YW-1:0] Y0    = '0;
  logic [XW-1:0] W     = '0;
  logic [YW-1:0] H     = '0;
  logic [CW-1:0] COLOR = '0;
  logic          BUSY, DONE;

  vga_fill_engine_if cpu_if();
  vga_fill_engine_if fb_if();

  always #5 CLK = ~CLK;

  vga_fill_engine dut (
    .CLK(CLK), .RST_N(RST_N), .cpu(cpu_if), .fb(fb_if),
    .START(START), .ABORT(ABORT), .X0(X0), .Y0(Y0), .W(W), .H(H),
    .COLOR(COLOR), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    string name;
    int x0, y0, w, h, color;
    int exp_n, exp_first, exp_last;
  } vec_t;

  vec_t vecs[NVEC];
  int   n_pass  = 0;
  int   n_total = 0;

  logic we_l[NCYC], done_l[NCYC], busy_l[NCYC];
  int   wa_l[NCYC], wd_l[NCYC];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one transaction starting in cycle 0 and record outputs at each negedge.
  task automatic capture(input int x0v, input int y0v, input int wv, input int hv,
                         input int colv, input int start2, input int cpu_c,
                         input int cwa, input int cwd, input int abort_c);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge CLK); #1;
      START = (c == 0) || (c == start2);
      if (c == 0) begin
        X0 = XW'(x0v); Y0 = YW'(y0v); W = XW'(wv); H = YW'(hv); COLOR = CW'(colv);
      end else begin
        X0 = 7'h55; Y0 = 6'h2a; W = 7'h7f; H = 6'h3f; COLOR = 8'hff;
      end
      cpu_if.we = (c == cpu_c);
      cpu_if.wa = AW'(cwa);
      cpu_if.wd = CW'(cwd);
      ABORT     = (c == abort_c);
      @(negedge CLK);
      we_l[c]   = fb_if.we;
      wa_l[c]   = int'(fb_if.wa);
      wd_l[c]   = int'(fb_if.wd);
      done_l[c] = DONE;
      busy_l[c] = BUSY;
    end
  endtask

  // Run a table vector with no CPU traffic and compare against a geometric model.
  task automatic run_vector(input int i, input int start2, input int abort_c);
    vec_t v;
    int   exp_wa[$];
    int   xe, ye, cnt, done_c, e_we, e_pat, e_addr, e_rng, e_done, e_busy;
    v = vecs[i];
    capture(v.x0, v.y0, v.w, v.h, v.color, start2, -1, 0, 0, abort_c);
    xe = (v.x0 + v.w > 80) ? 80 : v.x0 + v.w;
    ye = (v.y0 + v.h > 60) ? 60 : v.y0 + v.h;
    for (int y = v.y0; y < ye; y++)
      for (int x = v.x0; x < xe; x++)
        exp_wa.push_back(y * 128 + x);
    cnt = 0; e_pat = 0; e_addr = 0; e_rng = 0; e_done = 0; e_busy = 0;
    done_c = (v.exp_n > 0) ? 3 + v.exp_n : 2;
    for (int c = 0; c < NCYC; c++) begin
      e_we = (c >= 3 && c < 3 + v.exp_n) ? 1 : 0;
      if (we_l[c]) cnt++;
      if (int'(we_l[c]) != e_we) e_pat++;
      if (we_l[c] && e_we == 1) begin
        if (c - 3 >= exp_wa.size() || wa_l[c] != exp_wa[c-3] || wd_l[c] != v.color) e_addr++;
        if ((wa_l[c] % 128) >= 80 || (wa_l[c] / 128) >= 60) e_rng++;
      end
      if (int'(done_l[c]) != ((c == done_c) ? 1 : 0)) e_done++;
      if (int'(busy_l[c]) != ((c >= 1 && c <= done_c) ? 1 : 0)) e_busy++;
    end
    check({v.name, "_count"}, cnt, v.exp_n);
    check({v.name, "_we_pattern"}, e_pat, 0);
    check({v.name, "_addr_data_errs"}, e_addr, 0);
    check({v.name, "_range_errs"}, e_rng, 0);
    check({v.name, "_done_pattern"}, e_done, 0);
    check({v.name, "_busy_pattern"}, e_busy, 0);
    if (v.exp_n > 0) begin
      check({v.name, "_first_wa"}, wa_l[3], v.exp_first);
      check({v.name, "_last_wa"}, wa_l[2 + v.exp_n], v.exp_last);
    end
  endtask

  initial begin
    int e_wa[5];
    int e_wd[5];
    int errs;

    vecs[0] = '{"basic",  2,  3, 3, 2, 'hE0, 6,  386,  516};
    vecs[1] = '{"clip",  78, 59, 5, 4, 'h33, 2, 7630, 7631};
    vecs[2] = '{"w_zero", 5,  5, 0, 3, 'h11, 0,    0,    0};
    vecs[3] = '{"x_oob", 80, 10, 4, 2, 'h22, 0,    0,    0};
    vecs[4] = '{"pixel", 79,  0, 1, 1, 'h44, 1,   79,   79};
    vecs[5] = '{"yclip", 10, 58, 2, 5, 'h77, 4, 7434, 7563};

    cpu_if.we = 1'b0; cpu_if.wa = '0; cpu_if.wd = '0;

    // Reset values.
    #12;
    check("rst_fb_we", int'(fb_if.we), 0);
    check("rst_fb_wa", int'(fb_if.wa), 0);
    check("rst_fb_wd", int'(fb_if.wd), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    @(negedge CLK); RST_N = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vector(i, -1, -1);

    // CPU write lands in the second FILL cycle and delays the fill by one.
    capture(0, 0, 4, 1, 'h55, -1, 3, 100, 'h1C, -1);
    e_wa = '{0, 100, 1, 2, 3};
    e_wd = '{'h55, 'h1C, 'h55, 'h55, 'h55};
    errs = 0;
    for (int k = 0; k < 5; k++)
      if (!we_l[3+k] || wa_l[3+k] != e_wa[k] || wd_l[3+k] != e_wd[k]) errs++;
    check("cont_seq_errs", errs, 0);
    check("cont_we_after", int'(we_l[8]), 0);
    check("cont_done_c7", int'(done_l[7]), 0);
    check("cont_done_c8", int'(done_l[8]), 1);
    check("cont_busy_c9", int'(busy_l[9]), 0);

    // Abort after the third write, with a CPU write forwarded in the same cycle.
    capture(0, 0, 10, 10, 'h0F, -1, 5, 200, 'hAA, 5);
    errs = 0;
    for (int k = 0; k < 3; k++)
      if (!we_l[3+k] || wa_l[3+k] != k || wd_l[3+k] != 'h0F) errs++;
    check("abort_first3_errs", errs, 0);
    check("abort_cpu_we", int'(we_l[6]), 1);
    check("abort_cpu_wa", wa_l[6], 200);
    check("abort_cpu_wd", wd_l[6], 'hAA);
    errs = 0;
    for (int c = 7; c < NCYC; c++) if (we_l[c]) errs++;
    check("abort_no_more_writes", errs, 0);
    check("abort_done_c6", int'(done_l[6]), 1);
    check("abort_done_c7", int'(done_l[7]), 0);
    check("abort_busy_c6", int'(busy_l[6]), 1);
    check("abort_busy_c7", int'(busy_l[7]), 0);

    // Restart after abort; ABORT in IDLE and START in the DONE cycle are no-ops.
    run_vector(0, 9, 0);

    // Asynchronous reset between clock edges in the middle of a fill.
    @(posedge CLK); #1;
    START = 1'b1; X0 = '0; Y0 = '0; W = 7'd10; H = 6'd10; COLOR = 8'h3C;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("mid_fill_we", int'(fb_if.we), 1);
    check("mid_fill_busy", int'(BUSY), 1);
    RST_N = 1'b0;
    #1;
    check("async_rst_we", int'(fb_if.we), 0);
    check("async_rst_wa", int'(fb_if.wa), 0);
    check("async_rst_busy", int'(BUSY), 0);
    check("async_rst_done", int'(DONE), 0);
    repeat (2) @(posedge CLK);
    #3; RST_N = 1'b1;
    errs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (fb_if.we || BUSY || DONE) errs++;
    end
    check("post_rst_idle_errs", errs, 0);

    // CPU write while idle is forwarded on the next cycle.
    @(posedge CLK); #1;
    cpu_if.we = 1'b1; cpu_if.wa = 13'd1234; cpu_if.wd = 8'h99;
    @(posedge CLK); #1;
    cpu_if.we = 1'b0;
    check("idle_cpu_we", int'(fb_if.we), 1);
    check("idle_cpu_wa", int'(fb_if.wa), 1234);
    check("idle_cpu_wd", int'(fb_if.wd), 'h99);
    check("idle_busy", int'(BUSY), 0);
    @(posedge CLK); #1;
    check("idle_cpu_we_off", int'(fb_if.we), 0);

    run_vector(4, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
